dadda_mult_16: RTL and testbench

DADDA_MULT_16 -- requirements
Module: dadda_mult_16

---
 rtl/dadda_mult_16.sv | 140 ++++++++++++++
 tb/tb_dadda_mult_16.sv | 139 +++++++++++++
 2 files changed

// File: rtl/dadda_mult_16.sv
// Purpose : 16x16 unsigned multiplier, Dadda reduction tree plus one carry-propagate adder.
// Latency : 1 cycle (operands sampled at edge N, product valid after edge N).
// Backpr. : none; accepts one operand pair every cycle, no ready signal.
//
// Ports:
//   clk       - single clock, rising edge
//   rst       - synchronous active-high reset (clears out and out_valid)
//   in_valid  - a/b carry a new operand pair this cycle
//   a, b      - 16-bit unsigned operands
//   out       - registered 32-bit product, holds its value when in_valid is low
//   out_valid - one-cycle pulse per new product
module dadda_mult_16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] out,
  output logic        out_valid
);

  // Dadda height targets, applied in order.
  localparam int NSTAGE = 6;
  localparam int DTGT [NSTAGE] = '{13, 9, 6, 4, 3, 2};

  logic [16:0] col  [32];   // bits currently sitting in each column
  logic [16:0] ncol [32];   // columns being built by the current stage
  int          h    [32];
  int          nh   [32];
  logic [31:0] row0, row1;
  logic [31:0] prod;
  logic [31:0] out_d, out_q;
  logic        out_valid_d, out_valid_q;

  // The column heights are pure functions of the constant partial-product
  // shape, so every loop below unrolls into a fixed adder netlist.
  always_comb begin
    int p;
    int eff;
    for (int c = 0; c < 32; c++) begin
      col[c]  = '0;
      ncol[c] = '0;
      h[c]    = 0;
      nh[c]   = 0;
    end
    row0 = '0;
    row1 = '0;

    // Partial products: pp[i][j] = a[j] & b[i], weight i+j.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        col[i+j][h[i+j]] = a[j] & b[i];
        h[i+j]           = h[i+j] + 1;
      end
    end

    for (int s = 0; s < NSTAGE; s++) begin
      for (int c = 0; c < 32; c++) begin
        ncol[c] = '0;
        nh[c]   = 0;
      end
      for (int c = 0; c < 32; c++) begin
        // nh[c] already counts carries arriving from column c-1 this stage;
        // they contribute to the height but are not fed to this stage's adders.
        p   = 0;
        eff = h[c] + nh[c];
        for (int k = 0; k < 8; k++) begin
          if (eff > DTGT[s]) begin
            if (eff == DTGT[s] + 1) begin
              // Half adder: removes exactly one bit from the column.
              ncol[c][nh[c]] = col[c][p] ^ col[c][p+1];
              nh[c]          = nh[c] + 1;
              if (c < 31) begin
                ncol[c+1][nh[c+1]] = col[c][p] & col[c][p+1];
                nh[c+1]            = nh[c+1] + 1;
              end
              p   = p + 2;
              eff = eff - 1;
            end else begin
              // Full adder: removes two bits from the column.
              ncol[c][nh[c]] = col[c][p] ^ col[c][p+1] ^ col[c][p+2];
              nh[c]          = nh[c] + 1;
              if (c < 31) begin
                ncol[c+1][nh[c+1]] = (col[c][p]   & col[c][p+1]) |
                                     (col[c][p]   & col[c][p+2]) |
                                     (col[c][p+1] & col[c][p+2]);
                nh[c+1]            = nh[c+1] + 1;
              end
              p   = p + 3;
              eff = eff - 2;
            end
          end
        end
        // Bits not consumed by an adder pass straight through.
        for (int r = 0; r < 17; r++) begin
          if (r >= p && r < h[c]) begin
            ncol[c][nh[c]] = col[c][r];
            nh[c]          = nh[c] + 1;
          end
        end
      end
      for (int c = 0; c < 32; c++) begin
        col[c] = ncol[c];
        h[c]   = nh[c];
      end
    end

    for (int c = 0; c < 32; c++) begin
      if (h[c] > 0) row0[c] = col[c][0];
      if (h[c] > 1) row1[c] = col[c][1];
    end
  end

  // Final CPA. The product never exceeds 32 bits, so the carry out of bit 31
  // is always zero and is dropped by the 32-bit result width.
  assign prod = row0 + row1;

  always_comb begin
    out_d       = out_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      out_d       = prod;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_dadda_mult_16.sv
module tb_dadda_mult_16;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic [31:0] out;
  logic        out_valid;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Directed pairs with hand-computed products.
  logic [15:0] va [6] = '{16'h0002, 16'h0000, 16'hFFFF, 16'h1234, 16'h00F0, 16'hFFFF};
  logic [15:0] vb [6] = '{16'h0003, 16'hABCD, 16'h0001, 16'h5678, 16'h0F00, 16'hFFFF};
  logic [31:0] vp [6] = '{32'h00000006, 32'h00000000, 32'h0000FFFF,
                          32'h06260060, 32'h000E1000, 32'hFFFE0001};

  dadda_mult_16 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out       (out),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive on the falling edge, then let one rising edge pass and settle.
  task automatic step(input logic r, input logic v, input logic [15:0] aa, input logic [15:0] bb);
    @(negedge clk);
    rst      = r;
    in_valid = v;
    a        = aa;
    b        = bb;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 16'h0, 16'h0);
    step(1'b1, 1'b0, 16'h0, 16'h0);
    total_cnt++;
    if ({out_valid, out} !== {1'b0, 32'h0}) begin
      $display("FAIL reset_state: out_valid=%0b out=%08h, want out_valid=0 out=00000000", out_valid, out);
    end else pass_cnt++;
  endtask

  task automatic test_directed();
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, va[i], vb[i]);
      total_cnt++;
      if ({out_valid, out} !== {1'b1, vp[i]}) begin
        $display("FAIL directed_%0d: a=%04h b=%04h out_valid=%0b out=%08h, want 1 %08h",
                 i, va[i], vb[i], out_valid, out, vp[i]);
      end else pass_cnt++;
      // Gap cycle: product held, valid dropped.
      step(1'b0, 1'b0, 16'h5555, 16'hAAAA);
      total_cnt++;
      if ({out_valid, out} !== {1'b0, vp[i]}) begin
        $display("FAIL directed_hold_%0d: out_valid=%0b out=%08h, want 0 %08h", i, out_valid, out, vp[i]);
      end else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, va[i], vb[i]);
      total_cnt++;
      if ({out_valid, out} !== {1'b1, vp[i]}) begin
        $display("FAIL b2b_%0d: out_valid=%0b out=%08h, want 1 %08h", i, out_valid, out, vp[i]);
      end else pass_cnt++;
    end
    step(1'b0, 1'b0, 16'h1111, 16'h2222);
    total_cnt++;
    if ({out_valid, out} !== {1'b0, 32'hFFFE0001}) begin
      $display("FAIL b2b_idle: out_valid=%0b out=%08h, want 0 fffe0001", out_valid, out);
    end else pass_cnt++;
  endtask

  task automatic test_reset_during_valid();
    step(1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
    total_cnt++;
    if ({out_valid, out} !== {1'b0, 32'h0}) begin
      $display("FAIL rst_with_valid: out_valid=%0b out=%08h, want 0 00000000", out_valid, out);
    end else pass_cnt++;
    // First cycle after reset release is accepted normally.
    step(1'b0, 1'b1, 16'h0002, 16'h0003);
    total_cnt++;
    if ({out_valid, out} !== {1'b1, 32'h00000006}) begin
      $display("FAIL post_rst_first: out_valid=%0b out=%08h, want 1 00000006", out_valid, out);
    end else pass_cnt++;
  endtask

  task automatic test_random();
    logic [15:0] ra, rb;
    logic        rv;
    logic [31:0] last;
    logic [31:0] expv;
    last = 32'h00000006;
    for (int i = 0; i < 10000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rv = ($urandom_range(0, 7) != 0);
      if (i < 4) begin
        ra = (i[0]) ? 16'hFFFF : 16'h0000;
        rb = (i[1]) ? 16'hFFFF : 16'h8001;
        rv = 1'b1;
      end
      step(1'b0, rv, ra, rb);
      expv = rv ? ({16'h0, ra} * {16'h0, rb}) : last;
      last = expv;
      total_cnt++;
      if ({out_valid, out} !== {rv, expv}) begin
        $display("FAIL random_%0d: a=%04h b=%04h v=%0b out_valid=%0b out=%08h, want %0b %08h",
                 i, ra, rb, rv, out_valid, out, rv, expv);
      end else pass_cnt++;
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_during_valid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
